fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch queue between PC/instruction-memory fetch and the decode stage.
//  Buffers {pc, instr} pairs so fetch keeps running while decode stalls.
//  Valid/ready handshake on both sides; flush discards all entries on a control-flow redirect.
// PARAMETERS
//  DEPTH        4   number of entries; power of 2, >= 2
//  PC_WIDTH     32  width of the fetched PC
//  INSTR_WIDTH  32  width of the instruction word
// PORTS
//  clk        in   1            clock; all state updates on the rising edge
//  rst        in   1            reset; asynchronous, active-low
//  flush      in   1            synchronous flush; empties the queue
//  in_valid   in   1            fetch presents a valid {in_pc, in_instr}
//  in_ready   out  1            queue accepts a push this cycle
//  in_pc      in   PC_WIDTH     PC of the fetched instruction
//  in_instr   in   INSTR_WIDTH  instruction word read from instruction memory
//  out_valid  out  1            head entry is valid for decode
//  out_ready  in   1            decode consumes the head entry this cycle
//  out_pc     out  PC_WIDTH     PC of the head entry
//  out_instr  out  INSTR_WIDTH  instruction of the head entry
//  count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr, rd_ptr and count go to 0, so out_valid=0 and in_ready=1.
//    out_pc and out_instr read 0; storage contents are don't-care.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready. Both take effect at the rising edge.
//  - in_ready = (count != DEPTH) & ~flush. There is no pass-through when full:
//    a simultaneous pop while full does not enable a push in the same cycle.
//  - out_valid = (count != 0).
//  - out_pc/out_instr come combinationally from the head entry (mem[rd_ptr]).
//    With out_valid=0 they are forced to 0.
//  - Latency: an entry pushed at edge N is visible on the outputs after edge N (one cycle).
//    There is no empty-queue bypass.
//  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
//  - count tracks occupancy:
//    - push only: +1
//    - pop only: -1
//    - push and pop together: unchanged
//  - Push and pop in the same cycle on a non-empty, non-full queue: both occur.
//    The FIFO order is preserved.
//  - Pop when empty cannot happen (out_valid=0). Push when full cannot happen (in_ready=0).
//  - flush=1 at an edge:
//    - wr_ptr, rd_ptr and count go to 0.
//    - Any same-cycle push is dropped (in_ready=0 already).
//    - Any same-cycle pop is dropped: decode must ignore the head when flush=1.
//    - The cycle after flush: out_valid=0, in_ready=1.
//  - rst asserted mid-operation: immediate return to the reset state. All entries are lost.
//  - Ordering guarantee: entries leave in exactly the order accepted, with none duplicated or lost,
//    except through flush or rst.
//  - State machine (derived from count):
//    - EMPTY: count=0
//    - PARTIAL: 0<count<DEPTH
//    - FULL: count=DEPTH
//    - Transitions follow the push/pop rules above; flush goes to EMPTY from any state.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles, release -> out_valid=0, in_ready=1, count=0.
//  2. Fill: push pc=0x00,0x04,0x08,0x0C with out_ready=0 (DEPTH=4) -> count=4, in_ready=0.
//     A 5th push (pc=0x10) is held off. Then pop 4 -> pc order 0x00,0x04,0x08,0x0C, and count=0.
//  3. Streaming: in_valid=1 and out_ready=1 every cycle from pc=0x100 upward by 4 for 20 cycles.
//     -> one pop per cycle after the first; count stays at 1; pcs out in order.
//  4. Wrap-around: alternate 3 pushes / 2 pops for 12 cycles -> pointers wrap.
//     A scoreboard confirms exact order and count matches the model every cycle.
//  5. Flush: queue holds 3 entries; assert flush with in_valid=1 and out_ready=1.
//     -> next cycle count=0, out_valid=0; the flushed push never appears.
//     Then push pc=0x200 -> it is the next output.
//  6. Async reset mid-stream: drop rst between clock edges while count=2.
//     -> count=0 and out_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} pairs between fetch and decode.
// Valid/ready on both sides; flush empties the queue on a redirect.
module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic [INSTR_WIDTH-1:0]   in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    state_t                 r_state;

    logic                   w_push;
    logic                   w_pop;
    logic [CW-1:0]          w_count_nxt;
    state_t                 w_state_nxt;

    assign out_valid = (r_state != S_EMPTY);
    assign in_ready  = (r_state != S_FULL) & ~flush;
    assign w_push    = in_valid & in_ready;
    // A pop coinciding with flush is discarded along with everything else
    assign w_pop     = out_valid & out_ready & ~flush;
    assign count     = r_count;

    assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = S_PARTIAL;
        unique case (1'b1)
            (w_count_nxt == '0):         w_state_nxt = S_EMPTY;
            (w_count_nxt == CW'(DEPTH)): w_state_nxt = S_FULL;
            default:                     w_state_nxt = S_PARTIAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= S_EMPTY;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= S_EMPTY;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Storage needs no reset; the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: scenario tasks checked against a queue model.
// Inputs change 1ns after the rising edge; outputs are checked then too.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue updated from the handshake rules
    task automatic tick();
        bit push;
        bit pop;
        push = in_valid && rst && !flush && (q.size() < DEPTH);
        pop  = out_ready && rst && !flush && (q.size() > 0);
        @(posedge clk);
        #1;
        if (!rst || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{in_pc, in_instr});
        end
    endtask

    function automatic logic [31:0] exp_pc();
        return (q.size() != 0) ? q[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (q.size() != 0) ? q[0].instr : 32'h0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b count=%0d need 0 1 0",
                     out_valid, in_ready, count);
        end
        total++;
        if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: pc=%h instr=%h need 0 0", out_pc, out_instr);
        end
    endtask

    task automatic test_fill();
        logic [31:0] pcs [4];
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = pcs[i];
            in_instr = $urandom;
            tick();
            total++;
            if (count !== 3'(i + 1)) begin
                bad++;
                $display("FAIL fill_count: got %0d need %0d", count, i + 1);
            end
        end
        total++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL full: ready=%b count=%0d need 0 4", in_ready, count);
        end
        in_pc    = 32'h10;
        in_instr = $urandom;
        tick();
        total++;
        if (count !== 3'd4 || out_pc !== 32'h00) begin
            bad++;
            $display("FAIL held_off: count=%0d pc=%h need 4 0", count, out_pc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== exp_instr()) begin
                bad++;
                $display("FAIL fill_order: v=%b pc=%h instr=%h need 1 %h %h",
                         out_valid, out_pc, out_instr, pcs[i], exp_instr());
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drained: count=%0d valid=%b need 0 0", count, out_valid);
        end
    endtask

    task automatic test_streaming();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * (i - 1))) begin
                    bad++;
                    $display("FAIL stream_pc: v=%b pc=%h need 1 %h",
                             out_valid, out_pc, 32'h100 + 32'(4 * (i - 1)));
                end
            end
            in_pc    = 32'h100 + 32'(4 * i);
            in_instr = $urandom;
            tick();
            total++;
            if (count !== 3'd1) begin
                bad++;
                $display("FAIL stream_count: got %0d need 1", count);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] pc;
        pc = 32'h400;
        for (int i = 0; i < 12; i++) begin
            in_valid  = (i % 5) < 3;
            out_ready = (i % 5) >= 3;
            in_pc     = pc;
            in_instr  = $urandom;
            if (in_valid) pc += 4;
            tick();
            total++;
            if (count !== 3'(q.size()) || out_pc !== exp_pc() || out_instr !== exp_instr()) begin
                bad++;
                $display("FAIL wrap: count=%0d pc=%h instr=%h need %0d %h %h",
                         count, out_pc, out_instr, q.size(), exp_pc(), exp_instr());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0) begin
            total++;
            if (out_pc !== exp_pc() || out_instr !== exp_instr()) begin
                bad++;
                $display("FAIL wrap_drain: pc=%h instr=%h need %h %h",
                         out_pc, out_instr, exp_pc(), exp_instr());
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc    = 32'h300 + 32'(4 * i);
            in_instr = $urandom;
            tick();
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'hDEAD0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got %b need 0", in_ready);
        end
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush: count=%0d valid=%b ready=%b need 0 0 1",
                     count, out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_pc    = 32'h200;
        in_instr = $urandom;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 || count !== 3'd1) begin
            bad++;
            $display("FAIL after_flush: v=%b pc=%h count=%0d need 1 00000200 1",
                     out_valid, out_pc, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_pc     = pc;
            in_instr  = $urandom;
            pc += 4;
            #1;
            total++;
            if (in_ready !== (q.size() < DEPTH && !flush)) begin
                bad++;
                $display("FAIL rand_ready: got %b need %b",
                         in_ready, (q.size() < DEPTH && !flush));
            end
            tick();
            total++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) ||
                out_pc !== exp_pc() || out_instr !== exp_instr()) begin
                bad++;
                $display("FAIL rand: count=%0d v=%b pc=%h instr=%h need %0d %b %h %h",
                         count, out_valid, out_pc, out_instr,
                         q.size(), (q.size() != 0), exp_pc(), exp_instr());
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc    = 32'h500 + 32'(4 * i);
            in_instr = $urandom;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (count !== 3'd2) begin
            bad++;
            $display("FAIL pre_reset: count=%0d need 2", count);
        end
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: count=%0d v=%b pc=%h need 0 0 0",
                     count, out_valid, out_pc);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL post_reset: ready=%b count=%0d need 1 0", in_ready, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
